// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hit path, IDLE/REQ/FILL line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        cmiss_stall,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int LO_W  = OFF_W + 2;
    localparam int TAG_W = 32 - LO_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];
    logic [31:0]      r_miss_addr;
    logic [OFF_W-1:0] r_beat;
    logic             r_flush_seen;

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_miss_idx;
    logic [OFF_W-1:0] w_off;
    logic [TAG_W-1:0] w_tag;
    logic [TAG_W-1:0] w_miss_tag;
    logic             w_hit;
    logic             w_start_miss;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_unused_addr;

    assign w_idx         = req_addr[LO_W +: IDX_W];
    assign w_off         = req_addr[2 +: OFF_W];
    assign w_tag         = req_addr[31 -: TAG_W];
    assign w_miss_idx    = r_miss_addr[LO_W +: IDX_W];
    assign w_miss_tag    = r_miss_addr[31 -: TAG_W];
    assign w_unused_addr = &{1'b0, req_addr[1:0]};

    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_start_miss = (r_state == IDLE) && req_valid && !w_hit && !flush;
    assign w_beat       = (r_state == FILL) && mem_resp_valid;
    assign w_last_beat  = w_beat && (r_beat == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_miss) w_next_state = REQ;
            REQ:     if (mem_req_ready) w_next_state = FILL;
            FILL:    if (w_last_beat) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        cmiss_stall   = req_valid && (!w_hit || (r_state != IDLE));
        if (r_state == REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = r_miss_addr;
        end
        if (req_valid && w_hit && (r_state == IDLE)) begin
            resp_valid = 1'b1;
            resp_data  = r_data[w_idx][w_off];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_miss_addr  <= '0;
            r_beat       <= '0;
            r_flush_seen <= 1'b0;
        end else begin
            if (w_start_miss) begin
                r_miss_addr <= {req_addr[31:LO_W], {LO_W{1'b0}}};
            end
            if ((r_state == REQ) && mem_req_ready) begin
                r_beat <= '0;
            end else if (w_beat) begin
                r_beat <= r_beat + OFF_W'(1);
            end
            // A flush seen anywhere in the refill keeps the refilled line invalid.
            if (w_last_beat) begin
                r_flush_seen <= 1'b0;
            end else if (flush && (r_state != IDLE)) begin
                r_flush_seen <= 1'b1;
            end
            if (flush) begin
                r_valid <= '0;
            end else if (w_last_beat && !r_flush_seen) begin
                r_valid[w_miss_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[w_miss_idx][r_beat] <= mem_resp_data;
        end
        if (w_last_beat) begin
            r_tag[w_miss_idx] <= w_miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (resp_valid) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_start_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed refills with a backing-memory model,
// a table of lookup vectors, and scoreboards for refill requests and hit responses.
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        cmiss_stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_direct #(.LINES(16), .WORDS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .cmiss_stall    (cmiss_stall),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_memreq [$];
    logic [31:0] q_resp   [$];
    logic [31:0] m_exp;

    typedef struct {
        logic        rv;
        logic        fl;
        logic [31:0] addr;
        logic        exp_rv;
        logic        exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a[31:4] == 28'h4) begin
            return 32'h11 * (32'(a[3:2]) + 32'd1);
        end
        return ~a ^ 32'h3C3C_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Refill-request and hit-response scoreboards.
    always @(negedge clk) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            if (q_memreq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_req_unexpected: got %h expected none", mem_req_addr);
            end else begin
                m_exp = q_memreq.pop_front();
                chk("mem_req_addr", mem_req_addr, m_exp);
            end
        end
        if (resp_valid) begin
            if (q_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got %h addr %h expected no response", resp_data, req_addr);
            end else begin
                m_exp = q_resp.pop_front();
                chk("resp_data", resp_data, m_exp);
            end
        end
    end

    task automatic lookup(input logic rv, input logic fl, input logic [31:0] addr,
                          input logic erv, input logic es, input logic [31:0] ed, input string tag);
        @(posedge clk); #1;
        req_valid = rv; req_addr = addr; flush = fl;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        if (erv) q_resp.push_back(ed);
        @(negedge clk);
        chk($sformatf("%s resp_valid", tag), 32'(resp_valid), 32'(erv));
        chk($sformatf("%s stall", tag), 32'(cmiss_stall), 32'(es));
        if (!erv) chk($sformatf("%s resp_data", tag), resp_data, 32'h0);
        if (erv && !resp_valid && q_resp.size() != 0) void'(q_resp.pop_front());
    endtask

    task automatic refill(input logic [31:0] addr, input int ready_wait, input int flush_after,
                          input logic [31:0] redirect, input logic drop, input string tag);
        logic [31:0] line;
        line = {addr[31:4], 4'h0};
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        q_memreq.push_back(line);
        @(negedge clk);
        chk($sformatf("%s miss_stall", tag), 32'(cmiss_stall), 32'd1);
        chk($sformatf("%s miss_resp_valid", tag), 32'(resp_valid), 32'd0);
        for (int i = 0; i < ready_wait; i++) begin
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("%s hold_valid", tag), 32'(mem_req_valid), 32'd1);
            chk($sformatf("%s hold_addr", tag), mem_req_addr, line);
            chk($sformatf("%s hold_stall", tag), 32'(cmiss_stall), 32'd1);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s req_valid", tag), 32'(mem_req_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == flush_after + 1) begin
                @(posedge clk); #1;
                mem_req_ready = 1'b0; mem_resp_valid = 1'b0; flush = 1'b1;
                @(negedge clk);
                chk($sformatf("%s flush_gap_stall", tag), 32'(cmiss_stall), 32'(req_valid));
            end
            @(posedge clk); #1;
            mem_req_ready = 1'b0; flush = 1'b0;
            mem_resp_valid = 1'b1; mem_resp_data = memval(line + 32'(4 * k));
            if (k == 1 && redirect != 32'h0) req_addr = redirect;
            if (k == 1 && drop) req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s fill_stall", tag), 32'(cmiss_stall), 32'(req_valid));
            chk($sformatf("%s fill_req_valid", tag), 32'(mem_req_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h40,  1'b1, 1'b0, 32'h11};
        vecs[1] = '{1'b1, 1'b0, 32'h4C,  1'b1, 1'b0, 32'h44};
        vecs[2] = '{1'b1, 1'b0, 32'h44,  1'b1, 1'b0, 32'h22};
        vecs[3] = '{1'b1, 1'b0, 32'h48,  1'b1, 1'b0, 32'h33};
        vecs[4] = '{1'b0, 1'b0, 32'h40,  1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h999, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h43,  1'b1, 1'b0, 32'h11};
        vecs[7] = '{1'b1, 1'b0, 32'h4E,  1'b1, 1'b0, 32'h44};

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        #3;
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset cmiss_stall", 32'(cmiss_stall), 32'd0);
        chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset mem_req_addr", mem_req_addr, 32'd0);
        chk("reset resp_data", resp_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        refill(32'h40, 0, 99, 32'h0, 1'b0, "cold");
        for (int i = 0; i < 8; i++) begin
            lookup(vecs[i].rv, vecs[i].fl, vecs[i].addr, vecs[i].exp_rv,
                   vecs[i].exp_stall, vecs[i].exp_data, $sformatf("vec%0d", i));
        end

        refill(32'h140, 0, 99, 32'h0, 1'b0, "conflict_a");
        lookup(1'b1, 1'b0, 32'h144, 1'b1, 1'b0, memval(32'h144), "conflict_a_hit");
        refill(32'h40, 0, 99, 32'h0, 1'b0, "conflict_b");
        lookup(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'h11, "conflict_b_hit");

        refill(32'h1A4, 5, 99, 32'h0, 1'b0, "backpressure");
        lookup(1'b1, 1'b0, 32'h1A8, 1'b1, 1'b0, memval(32'h1A8), "backpressure_hit");

        refill(32'h80, 0, 1, 32'h0, 1'b0, "flush_fill");
        refill(32'h80, 0, 99, 32'h0, 1'b0, "flush_fill_again");
        lookup(1'b1, 1'b0, 32'h84, 1'b1, 1'b0, memval(32'h84), "flush_fill_hit");

        lookup(1'b1, 1'b1, 32'h84, 1'b1, 1'b0, memval(32'h84), "flush_idle_hit");
        refill(32'h84, 0, 99, 32'h0, 1'b0, "flush_idle_miss");
        lookup(1'b1, 1'b0, 32'h8C, 1'b1, 1'b0, memval(32'h8C), "flush_idle_refilled");

        refill(32'h100, 0, 99, 32'h200, 1'b0, "redir_a");
        refill(32'h200, 0, 99, 32'h0, 1'b0, "redir_a_next");
        lookup(1'b1, 1'b0, 32'h204, 1'b1, 1'b0, memval(32'h204), "redir_a_hit");
        refill(32'h100, 0, 99, 32'h2D0, 1'b0, "redir_b");
        refill(32'h2D0, 0, 99, 32'h0, 1'b0, "redir_b_next");
        lookup(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, memval(32'h100), "redir_b_old_line");
        lookup(1'b1, 1'b0, 32'h2D4, 1'b1, 1'b0, memval(32'h2D4), "redir_b_new_line");

        refill(32'h3E0, 0, 99, 32'h0, 1'b1, "drop");
        lookup(1'b1, 1'b0, 32'h3E8, 1'b1, 1'b0, memval(32'h3E8), "drop_hit");

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("spurious stall", 32'(cmiss_stall), 32'd0);
            chk("spurious mem_req_valid", 32'(mem_req_valid), 32'd0);
        end
        lookup(1'b1, 1'b0, 32'h3E0, 1'b1, 1'b0, memval(32'h3E0), "spurious_intact");

        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h500;
        @(negedge clk);
        chk("rst_req miss_stall", 32'(cmiss_stall), 32'd1);
        @(posedge clk); #2;
        chk("rst_req mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("rst_req mem_req_addr", mem_req_addr, 32'h500);
        reset = 1'b1;
        #1;
        chk("rst_async mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_async mem_req_addr", mem_req_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0001;
        @(posedge clk); #1;
        mem_resp_data = 32'hBAD0_0002;
        @(negedge clk);
        chk("post_rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        refill(32'h40, 0, 99, 32'h0, 1'b0, "post_rst");
        lookup(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'h11, "post_rst_hit");
        lookup(1'b1, 1'b0, 32'h48, 1'b1, 1'b0, 32'h33, "post_rst_hit2");

        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("memreq scoreboard drained", 32'(q_memreq.size()), 32'd0);
        chk("resp scoreboard drained", 32'(q_resp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
